// File: rtl/exc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : exc_ctrl_pkg
//  Purpose  : Shared definitions for the exception resolution stage:
//             exception codes, CP0 register indices, MEM exception flag bit
//             positions and the controller state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package exc_ctrl_pkg;

   // Width of the hardware interrupt bus
   localparam int INT_W = 6;

   // Exception codes driven to CP0 (zero means "no exception")
   localparam logic [31:0] EXC_NONE     = 32'h0000_0000;
   localparam logic [31:0] EXC_INT      = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL  = 32'h0000_0008;
   localparam logic [31:0] EXC_INVALID  = 32'h0000_000a;
   localparam logic [31:0] EXC_OVERFLOW = 32'h0000_000c;
   localparam logic [31:0] EXC_TRAP     = 32'h0000_000d;
   localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

   // CP0 register indices that may be bypassed from WB
   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   // Bit positions inside mem_exc_flags_i
   localparam int FLAG_SYSCALL  = 0;
   localparam int FLAG_INVALID  = 1;
   localparam int FLAG_TRAP     = 2;
   localparam int FLAG_OVERFLOW = 3;
   localparam int FLAG_ERET     = 4;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

endpackage : exc_ctrl_pkg
`default_nettype wire

// File: rtl/exc_ctrl_int_sync.sv
`default_nettype none
// ============================================================================
//  Module   : int_sync
//  Purpose  : Multi-flop synchroniser for the asynchronous interrupt lines.
//             int_sync_o is ext_int_i delayed by SYNC_STAGES clock edges.
//  Ports    : clk        - rising-edge clock
//             rst        - synchronous active-low reset
//             ext_int_i  - asynchronous interrupt lines
//             int_sync_o - synchronised interrupt lines
//  Revision : 1.0 - initial release
// ============================================================================
module int_sync
   import exc_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2   // must be at least 2 for metastability margin
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [INT_W-1:0] ext_int_i,
   output logic [INT_W-1:0] int_sync_o
);

   logic [INT_W-1:0] sync_q [SYNC_STAGES];
   logic [INT_W-1:0] sync_d [SYNC_STAGES];

   // Shift chain: stage 0 captures the raw lines, each later stage copies
   // the one before it.
   always_comb begin
      sync_d[0] = ext_int_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q <= sync_d;
      end
   end

   assign int_sync_o = sync_q[SYNC_STAGES-1];

endmodule : int_sync
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : exc_ctrl
//  Purpose  : Exception resolution between the MEM stage and CP0. Merges MEM
//             exception flags with CP0 state (bypassing in-flight WB mtc0
//             writes), picks one exception code, drives CP0's exception
//             inputs and issues a one-cycle flush with the redirect PC, then
//             blocks further events for one more cycle while CP0 sets EXL.
//  Ports    : clk, rst (sync active-low)
//             ext_int_i / int_sync_o            - interrupt lines in / to CP0
//             mem_valid_i, mem_exc_flags_i,
//             mem_inst_addr_i, mem_in_delayslot_i - MEM stage info
//             cp0_status_i, cp0_cause_i, cp0_epc_i - CP0 state
//             wb_cp0_we_i, wb_cp0_waddr_i,
//             wb_cp0_data_i                      - WB mtc0 bypass
//             excepttype_o, cur_inst_addr_o,
//             is_in_delayslot_o                  - exception info to CP0
//             flush_o, new_pc_o                  - pipeline redirect
//             busy_o                             - high in FLUSH and HOLD
//  Revision : 1.0 - initial release
// ============================================================================
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [INT_W-1:0] ext_int_i,
   output logic [INT_W-1:0] int_sync_o,
   input  logic             mem_valid_i,
   input  logic [4:0]       mem_exc_flags_i,
   input  logic [31:0]      mem_inst_addr_i,
   input  logic             mem_in_delayslot_i,
   input  logic [31:0]      cp0_status_i,
   input  logic [31:0]      cp0_cause_i,
   input  logic [31:0]      cp0_epc_i,
   input  logic             wb_cp0_we_i,
   input  logic [4:0]       wb_cp0_waddr_i,
   input  logic [31:0]      wb_cp0_data_i,
   output logic [31:0]      excepttype_o,
   output logic [31:0]      cur_inst_addr_o,
   output logic             is_in_delayslot_o,
   output logic             flush_o,
   output logic [31:0]      new_pc_o,
   output logic             busy_o
);

   // ------------------------------------------------------------------
   // Interrupt synchroniser
   // ------------------------------------------------------------------
   int_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_int_sync (
      .clk        (clk),
      .rst        (rst),
      .ext_int_i  (ext_int_i),
      .int_sync_o (int_sync_o)
   );

   // ------------------------------------------------------------------
   // Effective CP0 values with WB mtc0 bypass
   // ------------------------------------------------------------------
   logic [31:0] eff_status;
   logic [31:0] eff_cause;
   logic [31:0] eff_epc;
   logic        int_pending;
   logic [31:0] exc_code;

   always_comb begin
      eff_status = cp0_status_i;
      eff_cause  = cp0_cause_i;
      eff_epc    = cp0_epc_i;
      if (wb_cp0_we_i) begin
         if (wb_cp0_waddr_i == CP0_STATUS) eff_status = wb_cp0_data_i;
         if (wb_cp0_waddr_i == CP0_EPC)    eff_epc    = wb_cp0_data_i;
         // Only the software-interrupt bits of Cause are writable by mtc0
         if (wb_cp0_waddr_i == CP0_CAUSE)  eff_cause[9:8] = wb_cp0_data_i[9:8];
      end
   end

   // IM[7:2] masks the hardware lines, IM[1:0] the software bits of Cause.
   // Interrupts need IE=1 and no exception already in progress (EXL=0).
   assign int_pending = (({int_sync_o, eff_cause[9:8]} & eff_status[15:8]) != 8'h00)
                        && eff_status[0] && !eff_status[1];

   // Fixed priority selection
   always_comb begin
      if (int_pending)                          exc_code = EXC_INT;
      else if (mem_exc_flags_i[FLAG_SYSCALL])   exc_code = EXC_SYSCALL;
      else if (mem_exc_flags_i[FLAG_INVALID])   exc_code = EXC_INVALID;
      else if (mem_exc_flags_i[FLAG_TRAP])      exc_code = EXC_TRAP;
      else if (mem_exc_flags_i[FLAG_OVERFLOW])  exc_code = EXC_OVERFLOW;
      else if (mem_exc_flags_i[FLAG_ERET])      exc_code = EXC_ERET;
      else                                      exc_code = EXC_NONE;
   end

   // Bits of the effective registers that play no part in the decision
   logic unused_bits;
   assign unused_bits = ^{eff_status[31:16], eff_status[7:2],
                          eff_cause[31:10], eff_cause[7:0]};

   // ------------------------------------------------------------------
   // Controller: IDLE -> FLUSH -> HOLD -> IDLE, all outputs registered
   // ------------------------------------------------------------------
   state_t      state_q,           state_d;
   logic [31:0] excepttype_q,      excepttype_d;
   logic [31:0] cur_inst_addr_q,   cur_inst_addr_d;
   logic        is_in_delayslot_q, is_in_delayslot_d;
   logic        flush_q,           flush_d;
   logic [31:0] new_pc_q,          new_pc_d;

   always_comb begin
      state_d           = state_q;
      excepttype_d      = EXC_NONE;
      cur_inst_addr_d   = 32'h0;
      is_in_delayslot_d = 1'b0;
      flush_d           = 1'b0;
      new_pc_d          = 32'h0;
      case (state_q)
         ST_IDLE: begin
            if (mem_valid_i && (exc_code != EXC_NONE)) begin
               excepttype_d      = exc_code;
               cur_inst_addr_d   = mem_inst_addr_i;
               is_in_delayslot_d = mem_in_delayslot_i;
               flush_d           = 1'b1;
               new_pc_d          = (exc_code == EXC_ERET) ? eff_epc : EXC_VECTOR;
               state_d           = ST_FLUSH;
            end
         end
         // Events seen here are dropped: the flush discards their instructions
         ST_FLUSH: state_d = ST_HOLD;
         // Gives CP0 one cycle to commit EXL before a new decision
         ST_HOLD:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q           <= ST_IDLE;
         excepttype_q      <= EXC_NONE;
         cur_inst_addr_q   <= 32'h0;
         is_in_delayslot_q <= 1'b0;
         flush_q           <= 1'b0;
         new_pc_q          <= 32'h0;
      end else begin
         state_q           <= state_d;
         excepttype_q      <= excepttype_d;
         cur_inst_addr_q   <= cur_inst_addr_d;
         is_in_delayslot_q <= is_in_delayslot_d;
         flush_q           <= flush_d;
         new_pc_q          <= new_pc_d;
      end
   end

   assign excepttype_o      = excepttype_q;
   assign cur_inst_addr_o   = cur_inst_addr_q;
   assign is_in_delayslot_o = is_in_delayslot_q;
   assign flush_o           = flush_q;
   assign new_pc_o          = new_pc_q;
   assign busy_o            = (state_q != ST_IDLE);

endmodule : exc_ctrl
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exc_ctrl
//  Purpose  : Self-checking bench for exc_ctrl: directed table, hand-written
//             multi-cycle sequences and randomized traffic against a
//             behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exc_ctrl;

   localparam int          SYNC_STAGES = 2;
   localparam logic [31:0] VEC         = 32'h0000_0020;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  ext_int;
   logic [5:0]  int_sync;
   logic        mem_valid;
   logic [4:0]  flags;
   logic [31:0] pc;
   logic        ds;
   logic [31:0] status, cause, epc;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [31:0] excepttype, cur_addr, new_pc;
   logic        in_ds, flush, busy;

   always #5 clk = ~clk;

   exc_ctrl #(.EXC_VECTOR(VEC), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk                (clk),
      .rst                (rst),
      .ext_int_i          (ext_int),
      .int_sync_o         (int_sync),
      .mem_valid_i        (mem_valid),
      .mem_exc_flags_i    (flags),
      .mem_inst_addr_i    (pc),
      .mem_in_delayslot_i (ds),
      .cp0_status_i       (status),
      .cp0_cause_i        (cause),
      .cp0_epc_i          (epc),
      .wb_cp0_we_i        (we),
      .wb_cp0_waddr_i     (waddr),
      .wb_cp0_data_i      (wdata),
      .excepttype_o       (excepttype),
      .cur_inst_addr_o    (cur_addr),
      .is_in_delayslot_o  (in_ds),
      .flush_o            (flush),
      .new_pc_o           (new_pc),
      .busy_o             (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [5:0]  m_sync[$];     // delay line, front = newest sample
   int          m_dead;        // cycles left during which events are ignored
   logic [31:0] m_code, m_addr, m_newpc;
   logic        m_ds, m_flush;

   function automatic logic [31:0] ref_code(input logic [5:0] isync);
      logic [31:0] s, c;
      logic        pend;
      s = (we && waddr == 5'd12) ? wdata : status;
      c = cause;
      if (we && waddr == 5'd13) c[9:8] = wdata[9:8];
      pend = ((({isync, c[9:8]}) & s[15:8]) != 8'h0) && s[0] && !s[1];
      if (pend)          return 32'h01;
      if (flags[0])      return 32'h08;
      if (flags[1])      return 32'h0a;
      if (flags[2])      return 32'h0d;
      if (flags[3])      return 32'h0c;
      if (flags[4])      return 32'h0e;
      return 32'h0;
   endfunction

   task automatic model_edge();
      logic [5:0]  cur;
      logic [31:0] code;
      m_code = 0; m_addr = 0; m_ds = 0; m_flush = 0; m_newpc = 0;
      if (!rst) begin
         m_dead = 0;
         foreach (m_sync[i]) m_sync[i] = '0;
      end else begin
         cur = m_sync[$];
         m_sync.push_front(ext_int);
         void'(m_sync.pop_back());
         if (m_dead > 0) begin
            m_dead--;
         end else begin
            code = ref_code(cur);
            if (mem_valid && code != 0) begin
               m_code  = code;
               m_addr  = pc;
               m_ds    = ds;
               m_flush = 1'b1;
               m_newpc = (code == 32'h0e) ? ((we && waddr == 5'd14) ? wdata : epc) : VEC;
               m_dead  = 2;
            end
         end
      end
   endtask

   // One clock edge: update model, then compare every output
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("int_sync",   {26'h0, int_sync}, {26'h0, m_sync[$]});
      chk("excepttype", excepttype, m_code);
      chk("cur_addr",   cur_addr, m_addr);
      chk("in_ds",      {31'h0, in_ds}, {31'h0, m_ds});
      chk("flush",      {31'h0, flush}, {31'h0, m_flush});
      chk("new_pc",     new_pc, m_newpc);
      chk("busy",       {31'h0, busy}, {31'h0, (m_dead != 0)});
   endtask

   task automatic idle_inputs();
      mem_valid = 0; flags = 0; pc = 0; ds = 0;
      status = 0; cause = 0; epc = 0; we = 0; waddr = 0; wdata = 0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        valid;
      logic [4:0]  flags;
      logic [31:0] pc;
      logic        ds;
      logic [31:0] status, cause, epc;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] exp_code;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{1'b1, 5'b00001, 32'h8000_1000, 1'b0, 32'h0, 32'h0, 32'h0,    1'b0, 5'd0,  32'h0,         32'h08, 32'h20};
      vecs[1]  = '{1'b1, 5'b10000, 32'h8000_2000, 1'b0, 32'h0, 32'h0, 32'h100,  1'b1, 5'd14, 32'h200,       32'h0e, 32'h200};
      vecs[2]  = '{1'b1, 5'b01110, 32'h8000_3000, 1'b0, 32'h0, 32'h0, 32'h0,    1'b0, 5'd0,  32'h0,         32'h0a, 32'h20};
      vecs[3]  = '{1'b1, 5'b00100, 32'h8000_0040, 1'b1, 32'h0, 32'h0, 32'h0,    1'b0, 5'd0,  32'h0,         32'h0d, 32'h20};
      vecs[4]  = '{1'b1, 5'b01000, 32'h8000_0044, 1'b0, 32'h0, 32'h0, 32'h0,    1'b0, 5'd0,  32'h0,         32'h0c, 32'h20};
      vecs[5]  = '{1'b1, 5'b00001, 32'h8000_0048, 1'b0, 32'h101, 32'h100, 32'h0, 1'b0, 5'd0, 32'h0,         32'h01, 32'h20};
      vecs[6]  = '{1'b1, 5'b00001, 32'h8000_004c, 1'b0, 32'h103, 32'h100, 32'h0, 1'b0, 5'd0, 32'h0,         32'h08, 32'h20};
      vecs[7]  = '{1'b1, 5'b00000, 32'h8000_0050, 1'b0, 32'h0, 32'h200, 32'h0,  1'b1, 5'd12, 32'h201,       32'h01, 32'h20};
      vecs[8]  = '{1'b1, 5'b00000, 32'h8000_0054, 1'b1, 32'h101, 32'h0, 32'h0,  1'b1, 5'd13, 32'h100,       32'h01, 32'h20};
      vecs[9]  = '{1'b1, 5'b00000, 32'h8000_0058, 1'b0, 32'h401, 32'h0, 32'h0,  1'b1, 5'd13, 32'hFFFF_FCFF, 32'h00, 32'h00};
      vecs[10] = '{1'b0, 5'b00001, 32'h8000_005c, 1'b0, 32'h0, 32'h0, 32'h0,    1'b0, 5'd0,  32'h0,         32'h00, 32'h00};
      vecs[11] = '{1'b1, 5'b10000, 32'h8000_0060, 1'b0, 32'h0, 32'h0, 32'h1234, 1'b1, 5'd11, 32'h999,       32'h0e, 32'h1234};
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] r;
      m_sync = {};
      for (int i = 0; i < SYNC_STAGES; i++) m_sync.push_back('0);
      m_dead = 0;
      rst = 0; ext_int = 0;
      idle_inputs();
      step(); step();
      chk("reset_excepttype", excepttype, 32'h0);
      chk("reset_flush", {31'h0, flush}, 32'h0);
      chk("reset_busy", {31'h0, busy}, 32'h0);
      rst = 1;

      // Table: each vector from IDLE, then let FLUSH/HOLD drain
      for (int v = 0; v < 12; v++) begin
         mem_valid = vecs[v].valid; flags = vecs[v].flags; pc = vecs[v].pc; ds = vecs[v].ds;
         status = vecs[v].status; cause = vecs[v].cause; epc = vecs[v].epc;
         we = vecs[v].we; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
         step();
         chk($sformatf("vec%0d_code", v), excepttype, vecs[v].exp_code);
         chk($sformatf("vec%0d_flush", v), {31'h0, flush}, {31'h0, (vecs[v].exp_code != 0)});
         chk($sformatf("vec%0d_addr", v), cur_addr, (vecs[v].exp_code != 0) ? vecs[v].pc : 32'h0);
         chk($sformatf("vec%0d_ds", v), {31'h0, in_ds}, {31'h0, vecs[v].ds && (vecs[v].exp_code != 0)});
         if (vecs[v].exp_code != 0)
            chk($sformatf("vec%0d_newpc", v), new_pc, vecs[v].exp_pc);
         idle_inputs();
         step(); step();
      end

      // Priority event, then an overflow presented through FLUSH and HOLD
      mem_valid = 1; flags = 5'b01110; pc = 32'h8000_0100;
      step();
      chk("prio_code", excepttype, 32'h0a);
      flags = 5'b01000;
      step();
      chk("flush_cycle_code", excepttype, 32'h0);
      chk("flush_cycle_busy", {31'h0, busy}, 32'h1);
      chk("flush_cycle_flush", {31'h0, flush}, 32'h0);
      step();
      chk("hold_drop_code", excepttype, 32'h0);
      chk("hold_busy_clear", {31'h0, busy}, 32'h0);
      idle_inputs();
      step();

      // Hardware interrupt through the synchroniser
      status = 32'h0000_0401; ext_int = 6'b000001;
      step();
      chk("sync_edge1", {26'h0, int_sync}, 32'h0);
      step();
      chk("sync_edge2", {26'h0, int_sync}, 32'h1);
      mem_valid = 1; pc = 32'h8000_0200;
      step();
      chk("hw_int_code", excepttype, 32'h01);
      mem_valid = 0;
      step(); step();
      status = 32'h0000_0403; mem_valid = 1;
      step();
      chk("hw_int_exl_code", excepttype, 32'h0);
      ext_int = 0; idle_inputs();
      step(); step(); step();

      // Reset while in FLUSH
      mem_valid = 1; flags = 5'b00001; pc = 32'h8000_0300;
      step();
      chk("pre_reset_flush", {31'h0, flush}, 32'h1);
      rst = 0; idle_inputs();
      step();
      chk("rst_flush", {31'h0, flush}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      rst = 1; mem_valid = 1; flags = 5'b00001; pc = 32'h8000_0304;
      step();
      chk("post_reset_code", excepttype, 32'h08);
      idle_inputs();
      step(); step();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         r = $urandom;
         rst = (r[5:0] != 6'd0);
         if (r[9:7] == 3'd0) begin
            r = $urandom;
            ext_int = r[5:0];
         end
         r = $urandom;
         mem_valid = (r[1:0] != 2'd0);
         flags = (r[3:2] == 2'd0) ? r[8:4] : 5'b0;
         ds = r[9];
         we = r[10];
         waddr = 5'd11 + 5'($urandom_range(0, 4));
         status = $urandom;
         r = $urandom;
         status[0] = (r[1:0] != 2'd0);
         status[1] = (r[3:2] == 2'd0);
         cause = $urandom;
         epc = $urandom;
         wdata = $urandom;
         pc = $urandom;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_exc_ctrl
`default_nettype wire
